gfx_scanout: RTL and testbench
==============================

# gfx_scanout

Scan-out end of the line-buffer interface in the aqms video path. It generates the horizontal and vertical pixel counters, issues a per-line `start` with the `line` number to the tile/sprite fetcher, and reads back the 5-bit palette indices the fetcher wrote. It resolves those indices through a 32-entry colour RAM (CRAM) and drives registered 6-bit RGB with syncs and a vblank interrupt pulse.

## Interface
- `H_ACTIVE`, 256, active pixels per line
- `H_TOTAL`, 342, pixels per line including blanking
- `HS_START` / `HS_END`, 280 / 306, hsync asserted for `hpos` in [HS_START, HS_END)
- `V_ACTIVE`, 192, active lines
- `V_TOTAL`, 262, lines per frame
- `VS_LINE`, 221, vsync asserted for this one line

Ports:
- `clk` in 1: system clock
- `reset` in 1: asynchronous, active-low reset
- `pix_en` in 1: pixel-advance enable; all counters and pipeline stages advance only when it is high
- `display_en` in 1: low forces the backdrop colour on all active pixels
- `mask_col0` in 1: high forces the backdrop colour on `hpos` 0..7
- `backdrop` in 4: backdrop colour, resolved as CRAM entry {1, backdrop}
- `line` out 8: line number for the fetcher
- `start` out 1: one-clk pulse that starts fetching `line`
- `linebuf_rdidx` out 8: line-buffer read index
- `linebuf_data` in 5: palette index, valid one clk after `linebuf_rdidx`
- `cram_wraddr` in 5, `cram_wrdata` in 6, `cram_wren` in 1: CPU CRAM write port (data {B[1:0], G[1:0], R[1:0]})
- `rgb` out 6: pixel colour, 0 outside active area
- `hsync`, `vsync` out 1: active-high syncs
- `vblank_irq` out 1: one-clk pulse
- `hpos` out 9, `vpos` out 9: current counters

## Operation
- `hpos` counts 0..H_TOTAL-1. On wrap, `vpos` increments 0..V_TOTAL-1 and then wraps to 0.
- Fetch issue: on the `pix_en` cycle where `hpos`==H_ACTIVE, let n = (`vpos`+1) mod V_TOTAL. If n < V_ACTIVE, pulse `start` for one clk and load `line`=n. `line` holds its value until the next issue.
- `start` is also issued for line 0 at `vpos`==V_TOTAL-1, so line 0 is prefetched.
- `linebuf_rdidx` = `hpos`[7:0] during the active area and 0 otherwise.
- Pipeline: S0 is the counters/rdidx, S1 registers `linebuf_data` and the control flags, S2 is the CRAM read, and S3 is the `rgb` register.
- Active pixel at S3: if `display_en`=0, or `mask_col0`=1 with `hpos`<8, output CRAM[{1,backdrop}]. Otherwise output CRAM[linebuf_data].
- Blank pixel at S3 (`hpos`≥H_ACTIVE or `vpos`≥V_ACTIVE): `rgb`=0.
- `vblank_irq` pulses once when `vpos` becomes V_ACTIVE at `hpos`=0.
- CRAM write has priority. A write and a read of the same entry in the same clk returns the old data.
- CRAM is not cleared by `reset`.
- Reset values: `hpos`=0, `vpos`=0, `line`=0, `start`=0, `rgb`=0, `hsync`=0, `vsync`=0, `vblank_irq`=0, `linebuf_rdidx`=0, all pipeline flags set to blank.
- Reset mid-frame restarts timing at (0,0) with no `start` pulse until the next issue point.

## Timing
- Pixel latency is 3 `pix_en` cycles from `hpos`=h to the matching `rgb`. `hsync`, `vsync` and the blank flags are delayed by the same 3 stages so they stay aligned with `rgb`.
- `start` pulse is exactly one `clk` wide, even when `pix_en` stays high.
- The fetcher therefore has H_TOTAL-H_ACTIVE+H_ACTIVE pixel cycles, i.e. one full line, per line.
- When `pix_en`=0, every register holds its value and `start` stays 0.

## Configuration
- `GFX_SCANOUT_CRAM_RD_EN` defined: adds ports `cram_rdaddr` (in, 5 bits) and `cram_rddata` (out, 6 bits). This is a second CRAM read port with 1-clk latency that is independent of `pix_en`. A read of an entry written in the same clk returns the old data.
- `GFX_SCANOUT_CRAM_RD_EN` undefined: these ports and the extra read logic are absent, and the rest of the behaviour is identical.

## Structure
- Shared package holds the default timing constants (H/V values) and the CRAM word layout (R/G/B field positions).
- One sub-module, `cram`: 32×6 RAM with one write port, the scan read port, and the optional CPU read port, all synchronous.

## Test plan
- Reset released, `pix_en`=1 constantly → first `start` pulse at `vpos`=0, `hpos`=256 with `line`=1. At `vpos`=261, `hpos`=256, `start` pulses with `line`=0. No `start` pulses for `vpos` 191..260.
- Write CRAM[5]=6'h2A, line buffer returns 5 at index 10 → `rgb`=6'h2A exactly 3 `pix_en` cycles after `hpos`=10.
- `backdrop`=4'h3, CRAM[19]=6'h0F, `mask_col0`=1 → `rgb`=6'h0F for pixels 0..7 and line-buffer colours from pixel 8 onward. With `display_en`=0, `rgb`=6'h0F across all 256 pixels.
- Blanking: `rgb`=0 at `hpos`=256..341. `hsync` is high for exactly 26 pixels aligned to the delayed `hpos` 280. `vsync` is high only for line 221. `vblank_irq` is a single clk at (0,192).
- `pix_en` toggling 1/0, and reset asserted at `vpos`=100 → counters freeze while `pix_en`=0. On reset, all outputs go to 0 immediately (asynchronous), and after release timing restarts at (0,0).
- With `GFX_SCANOUT_CRAM_RD_EN`: write 6'h15 to entry 7 while reading entry 7 in the same clk → `cram_rddata` shows the old value, then 6'h15 on the next read.

Source files
------------

// File: rtl/gfx_scanout_pkg.sv
// rtl/gfx_scanout_pkg.sv - timing constants and CRAM/pipeline types for gfx_scanout
package gfx_scanout_pkg;

  localparam logic [8:0] H_ACTIVE = 9'd256;
  localparam logic [8:0] H_TOTAL  = 9'd342;
  localparam logic [8:0] HS_START = 9'd280;
  localparam logic [8:0] HS_END   = 9'd306;
  localparam logic [8:0] V_ACTIVE = 9'd192;
  localparam logic [8:0] V_TOTAL  = 9'd262;
  localparam logic [8:0] VS_LINE  = 9'd221;

  // CRAM word layout: {B[1:0], G[1:0], R[1:0]}
  typedef struct packed {
    logic [1:0] b;
    logic [1:0] g;
    logic [1:0] r;
  } cram_word_t;

  typedef struct packed {
    logic active;
    logic force_bd;
    logic hs;
    logic vs;
  } pix_flags_t;

  localparam pix_flags_t FLAGS_BLANK = '0;

endpackage

// File: rtl/gfx_scanout_cram.sv
// rtl/gfx_scanout_cram.sv - 32x6 colour RAM, one write port, scan read port
// and optional CPU read port (GFX_SCANOUT_CRAM_RD_EN); reads return pre-write data.
module gfx_scanout_cram
  import gfx_scanout_pkg::*;
(
  input  logic       clk,
  input  logic       i_wren,
  input  logic [4:0] i_wraddr,
  input  cram_word_t i_wrdata,
  input  logic       i_scan_en,
  input  logic [4:0] i_scan_addr,
`ifdef GFX_SCANOUT_CRAM_RD_EN
  input  logic [4:0] i_cpu_addr,
  output cram_word_t o_cpu_data,
`endif
  output cram_word_t o_scan_data
);

  cram_word_t r_mem [32];
  cram_word_t r_scan_q;

  always_ff @(posedge clk) begin
    if (i_wren) r_mem[i_wraddr] <= i_wrdata;
    if (i_scan_en) r_scan_q <= r_mem[i_scan_addr];
  end

  assign o_scan_data = r_scan_q;

`ifdef GFX_SCANOUT_CRAM_RD_EN
  cram_word_t r_cpu_q;

  always_ff @(posedge clk) begin
    r_cpu_q <= r_mem[i_cpu_addr];
  end

  assign o_cpu_data = r_cpu_q;
`endif

endmodule

// File: rtl/gfx_scanout.sv
// rtl/gfx_scanout.sv - scan-out timing, fetch issue and palette pipeline;
// GFX_SCANOUT_CRAM_RD_EN adds the CPU CRAM read port.
module gfx_scanout
  import gfx_scanout_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       pix_en,
  input  logic       display_en,
  input  logic       mask_col0,
  input  logic [3:0] backdrop,
  output logic [7:0] line,
  output logic       start,
  output logic [7:0] linebuf_rdidx,
  input  logic [4:0] linebuf_data,
  input  logic [4:0] cram_wraddr,
  input  logic [5:0] cram_wrdata,
  input  logic       cram_wren,
`ifdef GFX_SCANOUT_CRAM_RD_EN
  input  logic [4:0] cram_rdaddr,
  output logic [5:0] cram_rddata,
`endif
  output logic [5:0] rgb,
  output logic       hsync,
  output logic       vsync,
  output logic       vblank_irq,
  output logic [8:0] hpos,
  output logic [8:0] vpos
);

  logic [8:0] r_hpos, r_vpos;
  logic [7:0] r_line;
  logic       r_start, r_irq, r_hsync, r_vsync, r_pen_d;
  logic [4:0] r_lb_hold;
  pix_flags_t r_s1, r_s2;
  cram_word_t r_rgb;

  logic       w_h_last, w_v_last, w_active, w_issue;
  logic [8:0] w_next_line;
  logic [4:0] w_lb, w_scan_addr;
  pix_flags_t w_s0;
  cram_word_t w_cram_q;

  assign w_h_last    = (r_hpos == H_TOTAL - 9'd1);
  assign w_v_last    = (r_vpos == V_TOTAL - 9'd1);
  assign w_next_line = w_v_last ? 9'd0 : r_vpos + 9'd1;
  assign w_active    = (r_hpos < H_ACTIVE) && (r_vpos < V_ACTIVE);
  // Issue one pixel early so start/line are visible while hpos==H_ACTIVE.
  assign w_issue     = pix_en && (r_hpos == H_ACTIVE - 9'd1) && (w_next_line < V_ACTIVE);

  assign w_s0 = '{active:   w_active,
                  force_bd: !display_en || (mask_col0 && (r_hpos < 9'd8)),
                  hs:       (r_hpos >= HS_START) && (r_hpos < HS_END),
                  vs:       (r_vpos == VS_LINE)};

  // Line-buffer data for a pixel arrives the clk after its last pix_en cycle;
  // hold it so pix_en gaps cannot replace it with the next pixel's data.
  assign w_lb        = r_pen_d ? linebuf_data : r_lb_hold;
  assign w_scan_addr = r_s1.force_bd ? {1'b1, backdrop} : w_lb;

  gfx_scanout_cram u_cram (
    .clk         (clk),
    .i_wren      (cram_wren),
    .i_wraddr    (cram_wraddr),
    .i_wrdata    (cram_wrdata),
    .i_scan_en   (pix_en),
    .i_scan_addr (w_scan_addr),
`ifdef GFX_SCANOUT_CRAM_RD_EN
    .i_cpu_addr  (cram_rdaddr),
    .o_cpu_data  (cram_rddata),
`endif
    .o_scan_data (w_cram_q)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hpos    <= '0;
      r_vpos    <= '0;
      r_line    <= '0;
      r_start   <= 1'b0;
      r_irq     <= 1'b0;
      r_pen_d   <= 1'b0;
      r_lb_hold <= '0;
      r_s1      <= FLAGS_BLANK;
      r_s2      <= FLAGS_BLANK;
      r_rgb     <= '0;
      r_hsync   <= 1'b0;
      r_vsync   <= 1'b0;
    end else begin
      r_start <= w_issue;
      r_irq   <= pix_en && w_h_last && (r_vpos == V_ACTIVE - 9'd1);
      r_pen_d <= pix_en;
      if (r_pen_d) r_lb_hold <= linebuf_data;
      if (w_issue) r_line <= w_next_line[7:0];
      if (pix_en) begin
        r_hpos <= w_h_last ? 9'd0 : r_hpos + 9'd1;
        if (w_h_last) r_vpos <= w_next_line;
        r_s1    <= w_s0;
        r_s2    <= r_s1;
        r_rgb   <= r_s2.active ? w_cram_q : '0;
        r_hsync <= r_s2.hs;
        r_vsync <= r_s2.vs;
      end
    end
  end

  assign hpos          = r_hpos;
  assign vpos          = r_vpos;
  assign line          = r_line;
  assign start         = r_start;
  assign linebuf_rdidx = w_active ? r_hpos[7:0] : 8'd0;
  assign rgb           = r_rgb;
  assign hsync         = r_hsync;
  assign vsync         = r_vsync;
  assign vblank_irq    = r_irq;

endmodule

// File: tb/tb_gfx_scanout.sv
// tb/tb_gfx_scanout.sv - directed self-checking bench for gfx_scanout
module tb_gfx_scanout;

  logic       clk = 1'b0;
  logic       reset, pix_en, display_en, mask_col0;
  logic [3:0] backdrop;
  logic [7:0] line, linebuf_rdidx;
  logic       start, hsync, vsync, vblank_irq;
  logic [4:0] linebuf_data = '0;
  logic [4:0] cram_wraddr;
  logic [5:0] cram_wrdata, rgb;
  logic       cram_wren;
  logic [8:0] hpos, vpos;
`ifdef GFX_SCANOUT_CRAM_RD_EN
  logic [4:0] cram_rdaddr = '0;
  logic [5:0] cram_rddata;
`endif

  always #5 clk = ~clk;

  gfx_scanout dut (
    .clk           (clk),
    .reset         (reset),
    .pix_en        (pix_en),
    .display_en    (display_en),
    .mask_col0     (mask_col0),
    .backdrop      (backdrop),
    .line          (line),
    .start         (start),
    .linebuf_rdidx (linebuf_rdidx),
    .linebuf_data  (linebuf_data),
    .cram_wraddr   (cram_wraddr),
    .cram_wrdata   (cram_wrdata),
    .cram_wren     (cram_wren),
`ifdef GFX_SCANOUT_CRAM_RD_EN
    .cram_rdaddr   (cram_rdaddr),
    .cram_rddata   (cram_rddata),
`endif
    .rgb           (rgb),
    .hsync         (hsync),
    .vsync         (vsync),
    .vblank_irq    (vblank_irq),
    .hpos          (hpos),
    .vpos          (vpos)
  );

  logic [5:0] cram_m [32];
  logic [4:0] lb [256];

  // fetcher line buffer: synchronous read, data one clk after the index
  always @(posedge clk) linebuf_data <= lb[linebuf_rdidx];

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic cram_write(input logic [4:0] a, input logic [5:0] d);
    @(negedge clk);
    cram_wraddr = a; cram_wrdata = d; cram_wren = 1'b1;
    @(negedge clk);
    cram_wren = 1'b0;
  endtask

  // lines 4..7 mask column 0, lines 8..11 have display disabled
  function automatic logic [5:0] exp_px(input int dv, input int dh);
    if (dv >= 192 || dh >= 256) return 6'h00;
    if (dv >= 8 && dv <= 11) return cram_m[19];
    if (dv >= 4 && dv <= 7 && dh < 8) return cram_m[19];
    return cram_m[lb[dh]];
  endfunction

  initial begin
    int h, v, dp, dh, dv, ph, cnt;
    int pos_err, idx_err, rgb_err, hs_err, vs_err, vs_cnt, hs5, hs5_first;
    int start_cnt, start_err, irq_cnt, irq_err;
    int hold_err, tog_err, tog_start, first_start_h;
    logic [5:0] rb, e_rgb;
    logic e_hs, e_vs;

    reset = 1'b0; pix_en = 1'b1; display_en = 1'b1; mask_col0 = 1'b0;
    backdrop = 4'h3; cram_wren = 1'b0; cram_wraddr = '0; cram_wrdata = '0;

    for (int k = 0; k < 32; k++) cram_m[k] = 6'(k + 32);
    cram_m[5] = 6'h2A; cram_m[19] = 6'h0F;
    for (int k = 0; k < 256; k++) lb[k] = 5'(k);
    lb[10] = 5'd5;
    for (int k = 0; k < 32; k++) cram_write(5'(k), cram_m[k]);

    chk("rst_hpos", hpos, 0);
    chk("rst_vpos", vpos, 0);
    chk("rst_line", line, 0);
    chk("rst_start", start, 0);
    chk("rst_rgb", rgb, 0);
    chk("rst_syncs", {hsync, vsync, vblank_irq}, 0);
    chk("rst_rdidx", linebuf_rdidx, 0);

    @(negedge clk);
    reset = 1'b1;
    pos_err = 0; idx_err = 0; rgb_err = 0; hs_err = 0; vs_err = 0; vs_cnt = 0;
    hs5 = 0; hs5_first = -1; start_cnt = 0; start_err = 0; irq_cnt = 0; irq_err = 0;

    for (int i = 0; i < 262 * 342 + 20; i++) begin
      h = i % 342;
      v = (i / 342) % 262;
      if (hpos !== 9'(h) || vpos !== 9'(v)) pos_err++;
      if (linebuf_rdidx !== ((h < 256 && v < 192) ? 8'(h) : 8'd0)) idx_err++;
      dp = i - 3;
      if (dp < 0) begin
        e_rgb = 6'h00; e_hs = 1'b0; e_vs = 1'b0;
      end else begin
        dh = dp % 342;
        dv = (dp / 342) % 262;
        e_rgb = exp_px(dv, dh);
        e_hs = (dh >= 280 && dh < 306);
        e_vs = (dv == 221);
      end
      if (rgb !== e_rgb) rgb_err++;
      if (hsync !== e_hs) hs_err++;
      if (vsync !== e_vs) vs_err++;
      if (vsync) vs_cnt++;
      if (v == 5 && hsync) begin
        hs5++;
        if (hs5_first < 0) hs5_first = h;
      end
      if (start) begin
        start_cnt++;
        if (!(h == 256 && (v < 191 || v == 261)) || line !== 8'((v + 1) % 262)) start_err++;
      end
      if (vblank_irq) begin
        irq_cnt++;
        if (!(h == 0 && v == 192)) irq_err++;
      end
      if (v == 0 && h == 256)   chk("start_first", {start, line}, {1'b1, 8'd1});
      if (v == 261 && h == 256) chk("start_line0", {start, line}, {1'b1, 8'd0});
      if (v == 200 && h == 0)   chk("line_hold", line, 191);
      if (v == 0 && h == 12)    chk("px9", rgb, 6'h29);
      if (v == 0 && h == 13)    chk("px10_cram5", rgb, 6'h2A);
      if (v == 0 && h == 259)   chk("px256_blank", rgb, 6'h00);
      if (v == 4 && h == 3)     chk("mask_px0", rgb, 6'h0F);
      if (v == 4 && h == 10)    chk("mask_px7", rgb, 6'h0F);
      if (v == 4 && h == 11)    chk("mask_px8", rgb, 6'h28);
      if (v == 8 && h == 11)    chk("disp_off_px8", rgb, 6'h0F);
      if (v == 8 && h == 258)   chk("disp_off_px255", rgb, 6'h0F);
      if (v == 192 && h == 0)   chk("irq_at_192", vblank_irq, 1);
      if (h == 300) begin
        if (v == 3) mask_col0 = 1'b1;
        if (v == 7) begin mask_col0 = 1'b0; display_en = 1'b0; end
        if (v == 11) display_en = 1'b1;
      end
      @(negedge clk);
    end
    chk("frame_pos", pos_err, 0);
    chk("frame_rdidx", idx_err, 0);
    chk("frame_rgb", rgb_err, 0);
    chk("frame_hsync", hs_err, 0);
    chk("frame_vsync", vs_err, 0);
    chk("vsync_cycles", vs_cnt, 342);
    chk("hsync_width", hs5, 26);
    chk("hsync_rise_h", hs5_first, 283);
    chk("start_count", start_cnt, 192);
    chk("start_where", start_err, 0);
    chk("irq_count", irq_cnt, 1);
    chk("irq_where", irq_err, 0);

    // pix_en toggling from (0,20)
    ph = 20; hold_err = 0; tog_err = 0; tog_start = 0;
    for (int k = 0; k < 40; k++) begin
      pix_en = (k % 2 == 0);
      rb = rgb;
      @(negedge clk);
      if (pix_en) ph++;
      else if (rgb !== rb) hold_err++;
      if (hpos !== 9'(ph) || vpos !== 9'd0) tog_err++;
      if (start) tog_start++;
    end
    pix_en = 1'b1;
    chk("tog_pos", tog_err, 0);
    chk("tog_hold", hold_err, 0);
    chk("tog_start", tog_start, 0);
    chk("tog_hpos", hpos, 40);

    // reset in the middle of a frame
    cnt = 0;
    while (!(vpos == 9'd1 && hpos == 9'd50) && cnt < 2000) begin
      @(negedge clk);
      cnt++;
    end
    chk("reach_v1_h50", (cnt < 2000), 1);
    chk("pre_rst_line", line, 1);
    chk("pre_rst_rgb", rgb, 6'h2F);
    #2 reset = 1'b0;
    #1;
    chk("async_hpos", hpos, 0);
    chk("async_vpos", vpos, 0);
    chk("async_line", line, 0);
    chk("async_rgb", rgb, 0);
    chk("async_flags", {start, hsync, vsync, vblank_irq}, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    pos_err = 0; start_cnt = 0; first_start_h = -1;
    for (int i = 0; i < 300; i++) begin
      if (hpos !== 9'(i) || vpos !== 9'd0) pos_err++;
      if (start) begin
        start_cnt++;
        if (first_start_h < 0) first_start_h = i;
        if (line !== 8'd1) pos_err++;
      end
      @(negedge clk);
    end
    chk("rst2_pos", pos_err, 0);
    chk("rst2_start_cnt", start_cnt, 1);
    chk("rst2_start_h", first_start_h, 256);

`ifdef GFX_SCANOUT_CRAM_RD_EN
    cram_wraddr = 5'd7; cram_wrdata = 6'h15; cram_wren = 1'b1; cram_rdaddr = 5'd7;
    @(negedge clk);
    chk("cpu_rd_old", cram_rddata, 6'h27);
    cram_wren = 1'b0;
    @(negedge clk);
    chk("cpu_rd_new", cram_rddata, 6'h15);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
